periph_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single peripheral bus between the CPU load/store path (port 0) and a second bus master such as a DMA engine (port 1). It sits between the masters and the peripheral bus decoder. It sequences one transaction at a time onto the decoder's `address`/`write_data`/`we`/`re` inputs and returns the decoder's registered `read_data` to the owning port. Arbitration is round-robin, with an optional bus-lock feature.

---
 rtl/periph_bus_arbiter_if.sv | 44 ++++
 rtl/periph_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_if.sv
// ============================================================================
//  Module      : periph_bus_arbiter_if
//  Description : Two-master request/grant bundle plus peripheral decoder bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface periph_bus_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req_0, we_0, lock_0, gnt_0, rvalid_0;
    logic [ADDR_W-1:0] addr_0;
    logic [DATA_W-1:0] wdata_0, rdata_0;
    logic              req_1, we_1, lock_1, gnt_1, rvalid_1;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_1, rdata_1;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_we, bus_re, busy;
    logic [DATA_W-1:0] bus_read_data;

    // Arbiter side.
    modport slave (
        input  req_0, we_0, lock_0, addr_0, wdata_0,
        input  req_1, we_1, lock_1, addr_1, wdata_1,
        input  bus_read_data,
        output gnt_0, rvalid_0, rdata_0,
        output gnt_1, rvalid_1, rdata_1,
        output bus_address, bus_write_data, bus_we, bus_re, busy
    );

    // Masters and decoder side.
    modport master (
        output req_0, we_0, lock_0, addr_0, wdata_0,
        output req_1, we_1, lock_1, addr_1, wdata_1,
        output bus_read_data,
        input  gnt_0, rvalid_0, rdata_0,
        input  gnt_1, rvalid_1, rdata_1,
        input  bus_address, bus_write_data, bus_we, bus_re, busy
    );
endinterface

`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
// ============================================================================
//  Module      : periph_bus_arbiter
//  Description : Round-robin two-port arbiter onto the peripheral bus decoder.
//                Optional bus lock enabled by defining PERIPH_ARB_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module periph_bus_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  wire                  clk,
    input  wire                  rst,
    periph_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_last, w_last_nxt;
    logic              r_owner, w_owner_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt, w_rdata0_nxt, w_rdata1_nxt;
    logic              w_we_nxt, w_re_nxt, w_busy_nxt;
    logic              w_gnt0_nxt, w_gnt1_nxt, w_rvalid0_nxt, w_rvalid1_nxt;
    logic              w_any_req, w_win, w_win_we, w_rr_win;

    assign w_any_req = bus.req_0 | bus.req_1;
    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign w_rr_win  = bus.req_1 & (~bus.req_0 | ~r_last);
    assign w_win_we  = w_win ? bus.we_1 : bus.we_0;

`ifdef PERIPH_ARB_LOCK_EN
    logic r_lock_vld, r_lock_owner, w_lock_vld_nxt, w_lock_owner_nxt;
    logic w_owner_req;

    assign w_owner_req = r_lock_owner ? bus.req_1 : bus.req_0;
    assign w_win       = (r_lock_vld & w_owner_req) ? r_lock_owner : w_rr_win;
`else
    logic w_unused_lock;

    assign w_unused_lock = bus.lock_0 ^ bus.lock_1;
    assign w_win         = w_rr_win;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;
        w_addr_nxt    = bus.bus_address;
        w_wdata_nxt   = bus.bus_write_data;
        w_we_nxt      = 1'b0;
        w_re_nxt      = 1'b0;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_rvalid0_nxt = 1'b0;
        w_rvalid1_nxt = 1'b0;
        w_rdata0_nxt  = bus.rdata_0;
        w_rdata1_nxt  = bus.rdata_1;
`ifdef PERIPH_ARB_LOCK_EN
        w_lock_vld_nxt   = r_lock_vld;
        w_lock_owner_nxt = r_lock_owner;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef PERIPH_ARB_LOCK_EN
                // An idle lock owner must never stall the other port.
                if (r_lock_vld && !w_owner_req) begin
                    w_lock_vld_nxt = 1'b0;
                end
`endif
                if (w_any_req) begin
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_addr_nxt  = w_win ? bus.addr_1  : bus.addr_0;
                    w_wdata_nxt = w_win ? bus.wdata_1 : bus.wdata_0;
                    w_we_nxt    = w_win_we;
                    w_re_nxt    = ~w_win_we;
                    w_gnt0_nxt  = ~w_win;
                    w_gnt1_nxt  = w_win;
                    w_state_nxt = ST_CMD;
`ifdef PERIPH_ARB_LOCK_EN
                    w_lock_vld_nxt   = w_win ? bus.lock_1 : bus.lock_0;
                    w_lock_owner_nxt = w_win;
`endif
                end
            end
            ST_CMD: begin
                w_state_nxt = bus.bus_we ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (r_owner) begin
                    w_rdata1_nxt  = bus.bus_read_data;
                    w_rvalid1_nxt = 1'b1;
                end else begin
                    w_rdata0_nxt  = bus.bus_read_data;
                    w_rvalid0_nxt = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_last             <= 1'b1;
            r_owner            <= 1'b0;
            bus.bus_address    <= '0;
            bus.bus_write_data <= '0;
            bus.bus_we         <= 1'b0;
            bus.bus_re         <= 1'b0;
            bus.busy           <= 1'b0;
            bus.gnt_0          <= 1'b0;
            bus.gnt_1          <= 1'b0;
            bus.rvalid_0       <= 1'b0;
            bus.rvalid_1       <= 1'b0;
            bus.rdata_0        <= '0;
            bus.rdata_1        <= '0;
`ifdef PERIPH_ARB_LOCK_EN
            r_lock_vld         <= 1'b0;
            r_lock_owner       <= 1'b0;
`endif
        end else begin
            r_state            <= w_state_nxt;
            r_last             <= w_last_nxt;
            r_owner            <= w_owner_nxt;
            bus.bus_address    <= w_addr_nxt;
            bus.bus_write_data <= w_wdata_nxt;
            bus.bus_we         <= w_we_nxt;
            bus.bus_re         <= w_re_nxt;
            bus.busy           <= w_busy_nxt;
            bus.gnt_0          <= w_gnt0_nxt;
            bus.gnt_1          <= w_gnt1_nxt;
            bus.rvalid_0       <= w_rvalid0_nxt;
            bus.rvalid_1       <= w_rvalid1_nxt;
            bus.rdata_0        <= w_rdata0_nxt;
            bus.rdata_1        <= w_rdata1_nxt;
`ifdef PERIPH_ARB_LOCK_EN
            r_lock_vld         <= w_lock_vld_nxt;
            r_lock_owner       <= w_lock_owner_nxt;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
// ============================================================================
//  Module      : tb_periph_bus_arbiter
//  Description : Directed self-checking bench for periph_bus_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    periph_bus_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    periph_bus_arbiter #(.ADDR_W(14), .DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " gnt_0"},    {31'd0, bus.gnt_0},    32'd0);
        check({tag, " gnt_1"},    {31'd0, bus.gnt_1},    32'd0);
        check({tag, " rvalid_0"}, {31'd0, bus.rvalid_0}, 32'd0);
        check({tag, " rvalid_1"}, {31'd0, bus.rvalid_1}, 32'd0);
        check({tag, " bus_we"},   {31'd0, bus.bus_we},   32'd0);
        check({tag, " bus_re"},   {31'd0, bus.bus_re},   32'd0);
        check({tag, " busy"},     {31'd0, bus.busy},     32'd0);
    endtask

    int grants[$];
    int n1;
    int exp_lock_seq[4];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_0 = 0; bus.we_0 = 0; bus.lock_0 = 0; bus.addr_0 = '0; bus.wdata_0 = '0;
        bus.req_1 = 0; bus.we_1 = 0; bus.lock_1 = 0; bus.addr_1 = '0; bus.wdata_1 = '0;
        bus.bus_read_data = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_idle_outputs("reset");
        check("reset bus_address", {18'd0, bus.bus_address}, 32'd0);
        check("reset rdata_0", bus.rdata_0, 32'd0);

        // Port 0 read of 0x0304
        bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 14'h0304;
        step();
        check("rd gnt_0", {31'd0, bus.gnt_0}, 32'd1);
        check("rd gnt_1", {31'd0, bus.gnt_1}, 32'd0);
        check("rd bus_re", {31'd0, bus.bus_re}, 32'd1);
        check("rd bus_we", {31'd0, bus.bus_we}, 32'd0);
        check("rd bus_address", {18'd0, bus.bus_address}, 32'h0304);
        check("rd busy cmd", {31'd0, bus.busy}, 32'd1);
        bus.req_0 = 0;
        bus.bus_read_data = 32'hDEADBEEF;
        step();
        check("rd gnt_0 one-shot", {31'd0, bus.gnt_0}, 32'd0);
        check("rd bus_re one-shot", {31'd0, bus.bus_re}, 32'd0);
        check("rd rvalid_0 early", {31'd0, bus.rvalid_0}, 32'd0);
        check("rd busy resp", {31'd0, bus.busy}, 32'd1);
        step();
        bus.bus_read_data = 32'h0;
        check("rd rvalid_0", {31'd0, bus.rvalid_0}, 32'd1);
        check("rd rdata_0", bus.rdata_0, 32'hDEADBEEF);
        check("rd rvalid_1", {31'd0, bus.rvalid_1}, 32'd0);
        check("rd busy done", {31'd0, bus.busy}, 32'd0);
        step();
        check("rd rvalid_0 pulse", {31'd0, bus.rvalid_0}, 32'd0);
        check("rd rdata_0 hold", bus.rdata_0, 32'hDEADBEEF);

        // Port 1 write of 0xA5 to 0x0800
        bus.req_1 = 1; bus.we_1 = 1; bus.addr_1 = 14'h0800; bus.wdata_1 = 32'h000000A5;
        step();
        check("wr gnt_1", {31'd0, bus.gnt_1}, 32'd1);
        check("wr bus_we", {31'd0, bus.bus_we}, 32'd1);
        check("wr bus_re", {31'd0, bus.bus_re}, 32'd0);
        check("wr bus_address", {18'd0, bus.bus_address}, 32'h0800);
        check("wr bus_write_data", bus.bus_write_data, 32'h000000A5);
        bus.req_1 = 0;
        step();
        check("wr bus_we one-shot", {31'd0, bus.bus_we}, 32'd0);
        check("wr busy idle", {31'd0, bus.busy}, 32'd0);
        check("wr rvalid_1", {31'd0, bus.rvalid_1}, 32'd0);
        check("wr rdata_0 untouched", bus.rdata_0, 32'hDEADBEEF);

        // Reset during the RESP cycle of a port 0 read
        bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 14'h0010;
        step();
        check("rst-rd gnt_0", {31'd0, bus.gnt_0}, 32'd1);
        bus.req_0 = 0;
        bus.bus_read_data = 32'h12345678;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.bus_read_data = 32'h0;
        check_idle_outputs("mid-reset");
        check("mid-reset rdata_0", bus.rdata_0, 32'd0);
        check("mid-reset bus_address", {18'd0, bus.bus_address}, 32'd0);
        step();
        check("mid-reset rvalid_0 later", {31'd0, bus.rvalid_0}, 32'd0);

        // Both ports request continuously: expect 0,1,0,1
        bus.req_0 = 1; bus.we_0 = 1; bus.addr_0 = 14'h0001;
        bus.req_1 = 1; bus.we_1 = 1; bus.addr_1 = 14'h0002;
        grants.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.gnt_0) grants.push_back(0);
            if (bus.gnt_1) grants.push_back(1);
            check("rr no dual gnt", {31'd0, bus.gnt_0 & bus.gnt_1}, 32'd0);
            check("rr we/re exclusive", {31'd0, bus.bus_we & bus.bus_re}, 32'd0);
        end
        bus.req_0 = 0; bus.req_1 = 0;
        check("rr grant count", grants.size(), 32'd4);
        if (grants.size() == 4) begin
            check("rr grant[0]", grants[0], 32'd0);
            check("rr grant[1]", grants[1], 32'd1);
            check("rr grant[2]", grants[2], 32'd0);
            check("rr grant[3]", grants[3], 32'd1);
        end
        step();
        step();

        // Port 0 write alone so port 1 has priority on the next tie
        bus.req_0 = 1;
        step();
        check("pre-lock gnt_0", {31'd0, bus.gnt_0}, 32'd1);
        bus.req_0 = 0;
        step();

        // Port 1 three writes with lock 1,1,0; port 0 requests throughout
`ifdef PERIPH_ARB_LOCK_EN
        exp_lock_seq = '{1, 1, 1, 0};
`else
        exp_lock_seq = '{1, 0, 1, 0};
`endif
        bus.req_0 = 1; bus.req_1 = 1; bus.lock_1 = 1;
        n1 = 0;
        grants.delete();
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            step();
            if (bus.gnt_0) grants.push_back(0);
            if (bus.gnt_1) begin
                grants.push_back(1);
                n1++;
                bus.lock_1 = (n1 < 2);
                if (n1 == 3) bus.req_1 = 0;
            end
        end
        bus.req_0 = 0; bus.req_1 = 0; bus.lock_1 = 0;
        check("lock grant count", grants.size(), 32'd4);
        if (grants.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("lock grant[%0d]", i), grants[i], exp_lock_seq[i]);
            end
        end
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
